// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter over one single-ported synchronous memory.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is data priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t              r_state;
  logic                r_own_d;
  logic [3:0]          r_cnt;
  logic                r_en;
  logic                r_we;
  logic [3:0]          r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_ack;
  logic                r_d_ack;

  logic                w_gnt_d;
  logic                w_gnt_i;
  logic                w_grant;

  assign w_grant = (r_state == S_IDLE) & (d_req | if_req);

`ifdef MEM_ARB_RR_EN
  // 1 = data port was granted last; reset leaves fetch as last winner
  logic r_last_d;

  assign w_gnt_d = d_req & (~if_req | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst)
      r_last_d <= 1'b0;
    else if (w_grant)
      r_last_d <= w_gnt_d;
  end
`else
  assign w_gnt_d = d_req;
`endif

  assign w_gnt_i = if_req & ~w_gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_own_d    <= 1'b0;
      r_cnt      <= '0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
    end else begin
      r_en     <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_own_d <= w_gnt_d;
            r_addr  <= w_gnt_d ? d_addr : if_addr;
            r_we    <= w_gnt_d & d_we;
            r_be    <= w_gnt_d ? d_be : 4'hF;
            r_wdata <= w_gnt_d ? d_wdata : '0;
            r_en    <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // read data is valid on the cycle the count runs out
          if (r_cnt <= 4'd1) begin
            if (!r_we) begin
              if (r_own_d)
                r_d_rdata <= mem_rdata;
              else
                r_if_rdata <= mem_rdata;
            end
            r_d_ack  <= r_own_d;
            r_if_ack <= ~r_own_d;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = r_en;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign stall     = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

  logic w_unused;
  assign w_unused = w_gnt_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a MEM_LAT=2 memory model.
// Table of single transactions plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // memory: data valid two cycles after the issue cycle, junk otherwise
  logic [31:0] mem [256];
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [31:0] q1, q2;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    v1 <= mem_en & ~mem_we;
    q1 <= mem[mem_addr[9:2]];
    v2 <= v1;
    q2 <= q1;
    if (mem_en && mem_we)
      mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_be);
  end

  assign mem_rdata = v2 ? q2 : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // one access from IDLE; checks issue, latency, ack and data
  task automatic xact(input vec_t v);
    logic [31:0] prev_d;
    int cyc;
    int nis;
    bit got;
    prev_d = d_rdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("stall_req", 32'(stall), 32'd1);
    got = 1'b0; cyc = 0; nis = 0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (mem_en) begin
        nis++;
        chk("issue_cyc", 32'(cyc), 32'd1);
        chk("issue_addr", mem_addr, v.addr);
        chk("issue_we", 32'(mem_we), 32'(v.is_d & v.we));
        chk("issue_be", 32'(mem_be), v.is_d ? 32'(v.be) : 32'hF);
        if (v.is_d && v.we) chk("issue_wdata", mem_wdata, v.wdata);
      end
      if (if_ack || d_ack) begin
        got = 1'b1;
        chk("ack_cyc", 32'(cyc), 32'd4);
        chk("ack_port", 32'(d_ack), 32'(v.is_d));
        chk("stall_ack", 32'(stall), 32'd0);
        if (!v.is_d)
          chk("if_rdata", if_rdata, v.exp);
        else if (v.we)
          chk("d_rdata_store", d_rdata, prev_d);
        else
          chk("d_rdata", d_rdata, v.exp);
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    chk("issue_count", 32'(nis), 32'd1);
    tick();
    chk("ack_pulse", 32'({if_ack, d_ack}), 32'd0);
    chk("idle_en", 32'(mem_en), 32'd0);
  endtask

  task automatic chk_reset_vals;
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    bit ok;
    logic [31:0] order [4];

    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
    mem[32'h10 >> 2]  = 32'h00500093;
    mem[32'h104 >> 2] = 32'hFFC10113;
    mem[32'h20 >> 2]  = 32'h00000013;
    mem[32'h200 >> 2] = 32'hA5A50001;

    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h10,  32'h0,        32'h00500093};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h100, 32'h12345678, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h100, 32'h0,        32'hDEAD5678};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h104, 32'h0,        32'hFFC10113};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0;
    d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk_reset_vals();
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_noreq_en", 32'(mem_en), 32'd0);

    for (int k = 0; k < 6; k++) xact(vecs[k]);

`ifndef MEM_ARB_RR_EN
    // both ports in the same cycle: data first, fetch five cycles later
    begin
      int di, ii, da, ia;
      di = -1; ii = -1; da = -1; ia = -1; ok = 1'b1;
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
      cyc = 0;
      while (ia < 0 && cyc < 30) begin
        tick();
        cyc++;
        if (mem_en && mem_addr == 32'h200) di = cyc;
        if (mem_en && mem_addr == 32'h20) ii = cyc;
        if (!if_ack && !stall) ok = 1'b0;
        if (d_ack) begin
          da = cyc; d_req = 1'b0;
          chk("sim_d_rdata", d_rdata, 32'hA5A50001);
        end
        if (if_ack) begin
          ia = cyc; if_req = 1'b0;
          chk("sim_if_rdata", if_rdata, 32'h00000013);
        end
      end
      chk("sim_d_issue", 32'(di), 32'd1);
      chk("sim_d_ack", 32'(da), 32'd4);
      chk("sim_i_issue", 32'(ii), 32'd6);
      chk("sim_i_ack", 32'(ia), 32'd9);
      chk("sim_stall", 32'(ok), 32'd1);
      tick();
    end
`else
    // both ports held: grants alternate starting with data
    begin
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
        tick();
        cyc++;
        if (mem_en) order[n] = mem_addr;
        if (if_ack || d_ack) n++;
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("rr_count", 32'(n), 32'd4);
      chk("rr_g0", order[0], 32'h200);
      chk("rr_g1", order[1], 32'h20);
      chk("rr_g2", order[2], 32'h200);
      chk("rr_g3", order[3], 32'h20);
      tick();
    end
`endif

    // reset during the WAIT cycle of a load
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    tick(); tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk_reset_vals();
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (d_ack || if_ack || mem_en) ok = 1'b0;
    end
    chk("rst_no_ack", 32'(ok), 32'd1);
    xact(vecs[4]);

    // request held through the ack starts a second access
    begin
      int a1, a2, is2;
      a1 = -1; a2 = -1; is2 = -1;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
      cyc = 0;
      while (a2 < 0 && cyc < 30) begin
        tick();
        cyc++;
        if (mem_en && a1 >= 0) is2 = cyc;
        if (a1 >= 0 && cyc == a1 + 1) begin
          chk("b2b_stall_idle", 32'(stall), 32'd1);
          chk("b2b_idle_en", 32'(mem_en), 32'd0);
        end
        if (d_ack) begin
          chk("b2b_stall_ack", 32'(stall), 32'd0);
          if (a1 < 0) begin
            a1 = cyc;
            chk("b2b_rdata1", d_rdata, 32'hDEAD5678);
            d_addr = 32'h10;
          end else begin
            a2 = cyc;
            chk("b2b_rdata2", d_rdata, 32'h00500093);
            d_req = 1'b0;
          end
        end
      end
      chk("b2b_ack1", 32'(a1), 32'd4);
      chk("b2b_issue2", 32'(is2), 32'd6);
      chk("b2b_ack2", 32'(a2), 32'd9);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
